// File: rtl/transpose_sched.sv
// Tile sequencer in front of switch_top: admits tiles against output-buffer credits, holds the
// global switch ctrl steady while tiles are in flight, and returns {mode,tag} in issue order.
// Optional feature macro: TSCHED_PERF_EN adds saturating performance counter ports.
module transpose_sched #(
  parameter int NUM_MG     = 8,
  parameter int OBUF_DEPTH = 4,
  parameter int TAG_W      = 4,
  localparam int IDX_W     = $clog2(OBUF_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_mode,
  input  logic [TAG_W-1:0] req_tag,
  output logic             sw_rst,
  output logic             sw_ctrl,
  output logic             sw_in_val,
  input  logic             sw_out_val,
  output logic             obuf_wr_en,
  output logic [IDX_W-1:0] obuf_wr_idx,
  output logic [IDX_W-1:0] obuf_rd_idx,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_mode,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy,
  output logic [1:0]       dbg_state
`ifdef TSCHED_PERF_EN
  ,
  output logic [31:0]      perf_tiles,
  output logic [31:0]      perf_drain_cyc,
  output logic [31:0]      perf_bp_cyc
`endif
);

  // Handshakes: a transfer happens in any cycle where valid && ready is sampled high at the
  // rising clock edge; valid may not depend combinationally on ready.

  localparam int CNT_W = $clog2(OBUF_DEPTH + 1);
  localparam int FL_W  = $clog2(NUM_MG + 1);
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(OBUF_DEPTH);
  localparam logic [FL_W-1:0]  FLUSH_LAST = FL_W'(NUM_MG - 1);

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_RUN    = 2'd1,
    S_DRAIN  = 2'd2,
    S_MODESW = 2'd3
  } state_t;

  state_t            state, state_nx;
  logic [FL_W-1:0]   flush_cnt;
  logic              next_mode;
  logic [CNT_W-1:0]  inflight, occupied, credits;
  logic [IDX_W:0]    tq_wp, tq_rp;
  logic [TAG_W:0]    tq_mem [OBUF_DEPTH];
  logic              tq_full, tq_empty;
  logic              issue, out_ok, pop;

  // Credits come from registered counts, so a pop frees its slot one cycle later.
  assign credits  = DEPTH_C - inflight - occupied;
  assign tq_empty = (tq_wp == tq_rp);
  assign tq_full  = (tq_wp[IDX_W] != tq_rp[IDX_W]) &&
                    (tq_wp[IDX_W-1:0] == tq_rp[IDX_W-1:0]);

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    case (state)
      S_INIT:   if (flush_cnt == FLUSH_LAST) state_nx = S_RUN;
      S_RUN: begin
        req_ready = (req_mode == sw_ctrl) && (credits != '0) && !tq_full;
        if (req_valid && (req_mode != sw_ctrl)) state_nx = S_DRAIN;
      end
      S_DRAIN:  if (inflight == '0) state_nx = S_MODESW;
      S_MODESW: state_nx = S_RUN;
      default:  state_nx = S_INIT;
    endcase
  end

  assign issue      = req_valid && req_ready;
  assign sw_in_val  = issue;
  assign out_ok     = sw_out_val && (state != S_INIT);
  assign obuf_wr_en = out_ok;
  assign rsp_valid  = (occupied != '0) && !tq_empty;
  assign pop        = rsp_valid && rsp_ready;
  assign sw_rst     = (state == S_INIT);
  assign busy       = (state != S_RUN) || (inflight != '0) || rsp_valid;
  assign dbg_state  = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_INIT;
      flush_cnt <= '0;
      next_mode <= 1'b0;
      sw_ctrl   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_INIT) flush_cnt <= flush_cnt + 1'b1;
      else                 flush_cnt <= '0;
      if ((state == S_RUN) && (state_nx == S_DRAIN)) next_mode <= req_mode;
      // ctrl only moves once the pipeline is provably empty
      if (state == S_MODESW) sw_ctrl <= next_mode;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight    <= '0;
      occupied    <= '0;
      obuf_wr_idx <= '0;
      obuf_rd_idx <= '0;
      tq_wp       <= '0;
      tq_rp       <= '0;
    end else begin
      case ({issue, out_ok})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
      case ({out_ok, pop})
        2'b10:   occupied <= occupied + 1'b1;
        2'b01:   occupied <= occupied - 1'b1;
        default: occupied <= occupied;
      endcase
      if (out_ok) obuf_wr_idx <= obuf_wr_idx + 1'b1;
      if (pop)    obuf_rd_idx <= obuf_rd_idx + 1'b1;
      if (issue)  tq_wp <= tq_wp + 1'b1;
      if (pop)    tq_rp <= tq_rp + 1'b1;
    end
  end

  // Tag storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (issue) tq_mem[tq_wp[IDX_W-1:0]] <= {req_mode, req_tag};
  end

  assign {rsp_mode, rsp_tag} = tq_mem[tq_rp[IDX_W-1:0]];

`ifdef TSCHED_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_tiles     <= '0;
      perf_drain_cyc <= '0;
      perf_bp_cyc    <= '0;
    end else begin
      if (issue && (perf_tiles != '1)) perf_tiles <= perf_tiles + 32'd1;
      if (((state == S_DRAIN) || (state == S_MODESW)) && (perf_drain_cyc != '1))
        perf_drain_cyc <= perf_drain_cyc + 32'd1;
      if ((state == S_RUN) && req_valid && !req_ready && (perf_bp_cyc != '1))
        perf_bp_cyc <= perf_bp_cyc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_transpose_sched.sv
// Bench for transpose_sched: switch pipeline model, time-based reference model of
// results/credits, a vector table for back-pressure, directed corner sequences, random traffic.
module tb_transpose_sched;

  localparam int NUM_MG = 8;
  localparam int DEPTH  = 4;
  localparam int TAG_W  = 4;
  localparam int IDX_W  = 2;
  localparam int RING   = 64;

  logic             clk, rst;
  logic             req_valid, req_ready, req_mode;
  logic [TAG_W-1:0] req_tag;
  logic             sw_rst, sw_ctrl, sw_in_val, sw_out_val, obuf_wr_en;
  logic [IDX_W-1:0] obuf_wr_idx, obuf_rd_idx;
  logic             rsp_valid, rsp_ready, rsp_mode;
  logic [TAG_W-1:0] rsp_tag;
  logic             busy;
  logic [1:0]       dbg_state;
`ifdef TSCHED_PERF_EN
  logic [31:0]      perf_tiles, perf_drain_cyc, perf_bp_cyc;
`endif

  transpose_sched #(.NUM_MG(NUM_MG), .OBUF_DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode), .req_tag(req_tag),
    .sw_rst(sw_rst), .sw_ctrl(sw_ctrl), .sw_in_val(sw_in_val), .sw_out_val(sw_out_val),
    .obuf_wr_en(obuf_wr_en), .obuf_wr_idx(obuf_wr_idx), .obuf_rd_idx(obuf_rd_idx),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_mode(rsp_mode), .rsp_tag(rsp_tag),
    .busy(busy), .dbg_state(dbg_state)
`ifdef TSCHED_PERF_EN
    , .perf_tiles(perf_tiles), .perf_drain_cyc(perf_drain_cyc), .perf_bp_cyc(perf_bp_cyc)
`endif
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // switch_top stand-in: fixed NUM_MG-cycle valid pipeline, flushed by sw_rst
  logic [NUM_MG-1:0] sw_pipe;
  always @(posedge clk) begin
    if (sw_rst) sw_pipe <= '0;
    else        sw_pipe <= {sw_pipe[NUM_MG-2:0], sw_in_val};
  end
  assign sw_out_val = sw_pipe[NUM_MG-1];

  // ---------------- check bookkeeping ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  // Each tile leaves the switch NUM_MG cycles after issue and is visible downstream one
  // cycle later; results leave in issue order.
  logic [TAG_W:0] exp_q[$];
  int             exp_t_q[$];
  bit             iss_ring [RING];
  logic           prev_ctrl;
  int             ctrl_rise_cyc;
  int             inf_m, occ_m;
  logic [TAG_W-1:0] pop_tag_q[$];
  logic           pop_mode_q[$];
  int             pop_cyc_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      exp_t_q.delete();
      for (int i = 0; i < RING; i++) iss_ring[i] = 1'b0;
      prev_ctrl = 1'b0;
    end else begin
      inf_m = 0;
      for (int k = 1; k <= NUM_MG; k++) inf_m += int'(iss_ring[(cyc + RING - k) % RING]);
      occ_m = 0;
      foreach (exp_t_q[j]) if (exp_t_q[j] + NUM_MG + 1 <= cyc) occ_m++;
      chk("rsp_valid_model", rsp_valid, (occ_m != 0));
      chk("obuf_wr_en_model", obuf_wr_en, iss_ring[(cyc + RING - NUM_MG) % RING]);
      chk("credit_bound", (inf_m + occ_m) <= DEPTH, 1);
      if (rsp_valid && exp_q.size() != 0) chk("rsp_head", {rsp_mode, rsp_tag}, exp_q[0]);
      if (sw_ctrl !== prev_ctrl) begin
        chk("ctrl_change_with_inflight", inf_m, 0);
        if (sw_ctrl) ctrl_rise_cyc = cyc;
        prev_ctrl = sw_ctrl;
      end
      if (sw_in_val) begin
        chk("issue_without_credit", (inf_m + occ_m) < DEPTH, 1);
        chk("issue_mode", req_mode, sw_ctrl);
        exp_q.push_back({req_mode, req_tag});
        exp_t_q.push_back(cyc);
      end
      iss_ring[cyc % RING] = sw_in_val;
      if (rsp_valid && rsp_ready) begin
        chk("pop_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          void'(exp_t_q.pop_front());
        end
        pop_tag_q.push_back(rsp_tag);
        pop_mode_q.push_back(rsp_mode);
        pop_cyc_q.push_back(cyc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    pop_tag_q.delete();
    pop_mode_q.delete();
    pop_cyc_q.delete();
    ctrl_rise_cyc = -1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    req_valid = 1'b0;
    req_mode = 1'b0;
    repeat (n) tick();
    rst = 1'b1;
  endtask

  task automatic check_flush(input string nm);
    int cnt = 0;
    @(negedge clk);
    while (sw_rst && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    chk({nm, "_sw_rst_cycles"}, cnt, NUM_MG);
    chk({nm, "_state_run"}, dbg_state, 2'd1);
    chk({nm, "_req_ready"}, req_ready, 1);
    chk({nm, "_busy"}, busy, 0);
  endtask

  task automatic send_tile(input logic m, input logic [TAG_W-1:0] t, output int icyc);
    int guard = 0;
    req_valid = 1'b1;
    req_mode = m;
    req_tag = t;
    @(negedge clk);
    while (!req_ready && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    chk("send_accept", req_ready, 1);
    icyc = cyc;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    while ((busy || exp_q.size() != 0) && guard < 300) begin
      guard++;
      @(negedge clk);
    end
    chk("idle_reached", busy, 0);
    tick();
  endtask

  // ---------------- back-pressure vector table ----------------
  typedef struct {
    logic             req_valid;
    logic             rsp_ready;
    logic             exp_ready;
    logic             exp_rvalid;
    logic [TAG_W-1:0] exp_tag;
  } vec_t;

  vec_t vecs [19];

  initial begin
    int ia, ib, ic, idm, nrsp, n_iss;
    logic cur_m, accepted;

    rst = 1'b0; req_valid = 1'b0; req_mode = 1'b0; req_tag = '0; rsp_ready = 1'b0;

    // Offer a tile every cycle; rsp_ready held low for 13 cycles, then high.
    // Four tiles fill the buffer; each pop frees exactly one new admission a cycle later.
    for (int r = 0; r < 19; r++) begin
      vecs[r].req_valid  = 1'b1;
      vecs[r].rsp_ready  = (r >= 13);
      vecs[r].exp_ready  = (r < 4) || (r >= 14 && r <= 17);
      vecs[r].exp_rvalid = (r >= 9) && (r <= 16);
      vecs[r].exp_tag    = (r <= 13) ? '0 : TAG_W'(r - 13);
    end

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_obuf_wr_en", obuf_wr_en, 0);
    chk("reset_sw_rst", sw_rst, 1);
    chk("reset_sw_ctrl", sw_ctrl, 0);
    chk("reset_state", dbg_state, 2'd0);
    tick();
    rst = 1'b1;
    check_flush("init");
    tick();

    // Ten bypass tiles, tags 0..9
    clear_logs();
    rsp_ready = 1'b1;
    ia = 0;
    for (int i = 0; i < 10; i++) begin
      send_tile(1'b0, TAG_W'(i), ic);
      if (i == 0) ia = ic;
    end
    wait_idle();
    chk("b2b_count", pop_tag_q.size(), 10);
    for (int i = 0; i < 10 && i < pop_tag_q.size(); i++) chk("b2b_tag_order", pop_tag_q[i], i);
    if (pop_cyc_q.size() >= 4) begin
      chk("b2b_first_latency", pop_cyc_q[0] - ia, NUM_MG + 1);
      for (int i = 1; i < 4; i++) chk("b2b_rsp_no_gap", pop_cyc_q[i] - pop_cyc_q[i-1], 1);
    end

    // Back-pressure table
    for (int r = 0; r < 19; r++) begin
      req_valid = vecs[r].req_valid;
      req_mode  = 1'b0;
      req_tag   = TAG_W'(r);
      rsp_ready = vecs[r].rsp_ready;
      @(negedge clk);
      chk("bp_req_ready", req_ready, vecs[r].exp_ready);
      chk("bp_rsp_valid", rsp_valid, vecs[r].exp_rvalid);
      if (vecs[r].exp_rvalid) chk("bp_rsp_tag", rsp_tag, vecs[r].exp_tag);
      tick();
    end
    wait_idle();

    // Mode change: A,B bypass then C,D,E transpose, from a fresh reset
    do_reset(3);
    check_flush("reflush");
    tick();
    clear_logs();
    rsp_ready = 1'b1;
    send_tile(1'b0, 4'hA, ia);
    send_tile(1'b0, 4'hB, ib);
    send_tile(1'b1, 4'hC, ic);
    send_tile(1'b1, 4'hD, idm);
    send_tile(1'b1, 4'hE, idm);
    wait_idle();
    chk("ctrl_rise_after_B_out", ctrl_rise_cyc > ib + NUM_MG, 1);
    chk("C_gap_after_B", (ic - ib) >= NUM_MG + 1, 1);
    chk("mode_chg_count", pop_mode_q.size(), 5);
    if (pop_mode_q.size() == 5) begin
      chk("rsp_mode_A", pop_mode_q[0], 0);
      chk("rsp_mode_B", pop_mode_q[1], 0);
      chk("rsp_mode_C", pop_mode_q[2], 1);
      chk("rsp_tag_C", pop_tag_q[2], 4'hC);
    end
`ifdef TSCHED_PERF_EN
    chk("perf_tiles", perf_tiles, 5);
    chk("perf_drain_ge9", perf_drain_cyc >= 32'd9, 1);
`endif

    // Reset with one result buffered and two tiles in flight
    clear_logs();
    rsp_ready = 1'b0;
    send_tile(1'b1, 4'h5, idm);
    begin
      int guard = 0;
      @(negedge clk);
      while (!rsp_valid && guard < 50) begin
        guard++;
        @(negedge clk);
      end
      chk("buffered_ready", rsp_valid, 1);
      tick();
    end
    send_tile(1'b1, 4'h6, idm);
    send_tile(1'b1, 4'h7, idm);
    rst = 1'b0;
    #1;
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_req_ready", req_ready, 0);
    chk("midrst_obuf_wr_en", obuf_wr_en, 0);
    chk("midrst_sw_ctrl", sw_ctrl, 0);
    repeat (3) tick();
    rst = 1'b1;
    req_mode = 1'b0;
    check_flush("midrst");
    tick();
    rsp_ready = 1'b1;
    nrsp = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid) nrsp++;
    end
    chk("midrst_no_stale_rsp", nrsp, 0);
    tick();

    // Random traffic; requests hold until accepted
    clear_logs();
    cur_m = 1'b0;
    n_iss = 0;
    for (int c = 0; c < 500; c++) begin
      if (!req_valid && ($urandom_range(0, 3) != 0)) begin
        if ($urandom_range(0, 9) == 0) cur_m = ~cur_m;
        req_valid = 1'b1;
        req_mode  = cur_m;
        req_tag   = TAG_W'($urandom_range(0, 15));
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      accepted = req_valid && req_ready;
      if (accepted) n_iss++;
      tick();
      if (accepted) req_valid = 1'b0;
    end
    wait_idle();
    chk("rand_all_returned", pop_tag_q.size(), n_iss);
    chk("rand_traffic_seen", n_iss > 20, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
